midi_note_receiver: RTL
=======================

Name: midi_note_receiver

Overview:
Monophonic MIDI front end for the square-wave/ADSR voice. Deserialises a 31250-baud MIDI stream and parses Note On/Note Off messages on one channel. Drives the voice's freq_select, note_on and note_off inputs directly, as levels, so the ADSR FSM never misses an event.

Parameters:
CLKS_PER_BIT, 800, clk cycles per MIDI bit (25 MHz / 31250).
MIDI_CHANNEL, 0, 4-bit channel number accepted (0 = MIDI ch 1).
NOTE_BASE, 36, MIDI note mapped to freq_select 0 (C2).
NOTE_COUNT, 48, playable notes; NOTE_BASE..NOTE_BASE+NOTE_COUNT-1 (36..83, C2..B5).

Ports:
clk  input  1  system clock, 25 MHz
reset  input  1  asynchronous, active-high reset
midi_rx  input  1  raw MIDI serial input, idle high, asynchronous to clk
freq_select  output  6  note index to voice (0 = C2 … 47 = B5)
note_on  output  1  gate level; high while a note is held
note_off  output  1  always the complement of note_on
note_strobe  output  1  1-cycle pulse on every accepted Note On (incl. retrigger)
rx_error  output  1  1-cycle pulse on framing error
active_note  output  7  MIDI number of the held note; 0 when none

Behaviour:
- Reset values: freq_select=33 (A4), note_on=0, note_off=1, note_strobe=0, rx_error=0, active_note=0. UART returns to IDLE; running status is cleared; data count=0.
- Reset mid-byte or mid-message discards all partial state.
- midi_rx passes a 2-FF synchroniser (reset value 1). All logic uses the synchronised bit.
- UART RX FSM, states IDLE, START, DATA, STOP:
  - IDLE→START on a synchronised falling edge.
  - START: wait CLKS_PER_BIT/2. If the line is still 0 go to DATA, else return to IDLE (glitch).
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT apart.
  - STOP: sample one CLKS_PER_BIT later. If 1, pulse byte_valid with the byte for 1 cycle. If 0, pulse rx_error and drop the byte. Either way go to IDLE.
- Parser, driven by byte_valid:
  - Byte 0xF8..0xFF (realtime): ignored; running status and data count untouched.
  - Byte 0x8n or 0x9n with n==MIDI_CHANNEL: latch running status (OFF or ON); data count=0.
  - Any other status byte (0x80..0xF7): clear running status; following data bytes are ignored.
  - Data byte (<0x80) with valid running status: count 0 latches the note; count 1 latches velocity, executes the message, and resets count to 0. Running status is kept, so running-status streams work.
  - rx_error: data count=0; running status kept.
- Execution, registered 1 cycle after the velocity byte's byte_valid:
  - Notes outside NOTE_BASE..NOTE_BASE+NOTE_COUNT-1 are ignored entirely.
  - Note On, velocity>0: freq_select=note-NOTE_BASE, active_note=note, note_on=1, note_strobe pulses. Applies even if already gated (retrigger, last-note priority); the gate stays high with no gap.
  - Note Off, or Note On with velocity 0: only if note==active_note and note_on=1. Then note_on=0 and active_note=0; freq_select holds its last value so the release phase keeps its pitch. Otherwise ignored.
- freq_select and note_on change in the same cycle.
- Width rules: note-NOTE_BASE is computed in 7 bits; the range check precedes the subtraction, so no wrap-around occurs.
- Velocity magnitude is otherwise unused.

Decomposition:
- Shared package midi_pkg: MIDI_STATUS_NOTE_OFF=4'h8, MIDI_STATUS_NOTE_ON=4'h9, MIDI_REALTIME_MIN=8'hF8, the UART state enum, and the parser running-status enum.
- One sub-module, midi_uart_rx: synchroniser, bit timing, byte_valid/rx_error. The parser and note logic stay in the top module.

Test Plan:
- Reset then idle line → freq_select=33, note_on=0, note_off=1, no strobes; assert reset mid-byte → all outputs return to reset values and the next full byte parses correctly.
- Send 0x90,0x45,0x64 (A4 on, ch0) → 1 cycle after the third byte_valid: freq_select=33, note_on=1, note_off=0, active_note=0x45, note_strobe 1 cycle. Then 0x80,0x45,0x00 → note_on=0, freq_select stays 33.
- Running status: 0x90,0x3C,0x40,0x3E,0x40 → two strobes, freq_select 24 then 26, note_on stays 1. Then 0x3C,0x00 (stale note, velocity 0) → ignored, note_on=1. Then 0x3E,0x00 → note_on=0.
- Filtering:
  - 0x91,0x45,0x64 (ch1) → no change.
  - 0x90,0x23,0x64 (note 35) and 0x90,0x54,0x64 (note 84) → ignored.
  - 0x90,0x24,0x64 (note 36) → freq_select=0.
  - 0x90,0x53,0x64 (note 83) → freq_select=47.
- Interleaved realtime/other status: 0x90,0x45,0xF8,0x64 → note accepted. 0xB0,0x07,0x7F → ignored, running status cleared, so a following 0x45,0x64 is ignored.
- Framing error: byte with stop bit 0 → rx_error 1-cycle pulse, byte dropped. 0x90,0x45,<bad>,0x45,0x64 → exactly one Note On executed, from the last two bytes.

Source files
------------

// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI constants and state types
// Purpose: status nibbles, realtime threshold, reset pitch and the enums
//          used by the UART receiver and the note parser.
// Ports:   none (package).
package midi_pkg;

  localparam logic [3:0] MIDI_STATUS_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_STATUS_NOTE_ON  = 4'h9;
  localparam logic [7:0] MIDI_REALTIME_MIN    = 8'hF8;

  // A4 on the voice's note table; pitch held by the voice after reset.
  localparam logic [5:0] FREQ_SELECT_RESET    = 6'd33;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  typedef enum logic [1:0] {
    RS_NONE,
    RS_NOTE_OFF,
    RS_NOTE_ON
  } run_status_t;

endpackage

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI serial byte receiver
// Purpose: synchronises the raw MIDI line and deserialises 8N1 bytes.
// Ports:   clk, reset        - clock, async active-high reset
//          i_rx              - raw serial input, idle high
//          o_byte            - last received byte
//          o_byte_valid      - 1-cycle pulse, o_byte holds a good byte
//          o_rx_error        - 1-cycle pulse, stop bit sampled low
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_rx_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      r_state;
  uart_state_t      w_next_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_half_done;
  logic             w_full_done;

  assign w_half_done = (r_cnt == CNT_HALF);
  assign w_full_done = (r_cnt == CNT_FULL);
  assign o_byte      = r_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= UART_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      UART_IDLE:  if (r_prev && !r_sync2) w_next_state = UART_START;
      // Mid-bit recheck rejects glitches shorter than half a bit.
      UART_START: if (w_half_done) w_next_state = r_sync2 ? UART_IDLE : UART_DATA;
      UART_DATA:  if (w_full_done && (r_bit_idx == 3'd7)) w_next_state = UART_STOP;
      UART_STOP:  if (w_full_done) w_next_state = UART_IDLE;
      default:    w_next_state = UART_IDLE;
    endcase
  end

  always_comb begin
    o_byte_valid = 1'b0;
    o_rx_error   = 1'b0;
    if ((r_state == UART_STOP) && w_full_done) begin
      o_byte_valid = r_sync2;
      o_rx_error   = !r_sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_prev    <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        UART_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        UART_START: r_cnt <= w_half_done ? '0 : r_cnt + 1'b1;
        UART_DATA: begin
          if (w_full_done) begin
            r_cnt     <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_STOP: r_cnt <= r_cnt + 1'b1;
        default:   r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/midi_note_receiver.sv
// rtl/midi_note_receiver.sv - monophonic MIDI Note On/Off front end
// Purpose: parses Note On/Off on one channel and drives the voice gate/pitch.
// Ports:   clk, reset        - clock, async active-high reset
//          i_midi_rx         - raw MIDI serial input
//          o_freq_select     - note index to voice (0 = NOTE_BASE)
//          o_note_on         - gate level, high while a note is held
//          o_note_off        - complement of o_note_on
//          o_note_strobe     - 1-cycle pulse per accepted Note On
//          o_rx_error        - 1-cycle pulse on framing error
//          o_active_note     - MIDI number of held note, 0 when none
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 800,
  parameter int MIDI_CHANNEL = 0,
  parameter int NOTE_BASE    = 36,
  parameter int NOTE_COUNT   = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_midi_rx,
  output logic [5:0] o_freq_select,
  output logic       o_note_on,
  output logic       o_note_off,
  output logic       o_note_strobe,
  output logic       o_rx_error,
  output logic [6:0] o_active_note
);

  localparam logic [3:0] CHANNEL = 4'(MIDI_CHANNEL);
  localparam logic [6:0] NOTE_LO = 7'(NOTE_BASE);
  localparam logic [6:0] NOTE_HI = 7'(NOTE_BASE + NOTE_COUNT - 1);

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_rx_error;
  run_status_t r_run_status;
  logic        r_data_cnt;
  logic [6:0]  r_note;
  logic [5:0]  r_freq_select;
  logic        r_note_on;
  logic        r_note_strobe;
  logic [6:0]  r_active_note;
  logic        w_vel_byte;
  logic        w_in_range;
  logic [6:0]  w_note_idx;
  logic        w_exec_on;
  logic        w_exec_off;

  midi_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk          (clk),
    .reset        (reset),
    .i_rx         (i_midi_rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_rx_error   (w_rx_error)
  );

  // Second data byte of a message on our channel: the message executes now.
  assign w_vel_byte = w_byte_valid && !w_byte[7] && (r_run_status != RS_NONE) && r_data_cnt;
  assign w_in_range = (r_note >= NOTE_LO) && (r_note <= NOTE_HI);
  // Only used when w_in_range holds, so the subtraction never wraps.
  assign w_note_idx = r_note - NOTE_LO;

  assign w_exec_on  = w_vel_byte && w_in_range && (r_run_status == RS_NOTE_ON) &&
                      (w_byte[6:0] != 7'd0);
  // Release only the held note; stale offs from earlier notes are ignored.
  assign w_exec_off = w_vel_byte && w_in_range && !w_exec_on && r_note_on &&
                      (r_note == r_active_note);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_status <= RS_NONE;
      r_data_cnt   <= 1'b0;
      r_note       <= '0;
    end else if (w_rx_error) begin
      r_data_cnt <= 1'b0;
    end else if (w_byte_valid && (w_byte < MIDI_REALTIME_MIN)) begin
      if (w_byte[7]) begin
        r_data_cnt <= 1'b0;
        if ((w_byte[3:0] == CHANNEL) && (w_byte[7:4] == MIDI_STATUS_NOTE_ON))
          r_run_status <= RS_NOTE_ON;
        else if ((w_byte[3:0] == CHANNEL) && (w_byte[7:4] == MIDI_STATUS_NOTE_OFF))
          r_run_status <= RS_NOTE_OFF;
        else
          r_run_status <= RS_NONE;
      end else if (r_run_status != RS_NONE) begin
        if (!r_data_cnt) r_note <= w_byte[6:0];
        r_data_cnt <= !r_data_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_freq_select <= FREQ_SELECT_RESET;
      r_note_on     <= 1'b0;
      r_note_strobe <= 1'b0;
      r_active_note <= '0;
    end else begin
      r_note_strobe <= w_exec_on;
      if (w_exec_on) begin
        r_freq_select <= w_note_idx[5:0];
        r_active_note <= r_note;
        r_note_on     <= 1'b1;
      end else if (w_exec_off) begin
        // Pitch is held so the release phase keeps sounding the same note.
        r_active_note <= '0;
        r_note_on     <= 1'b0;
      end
    end
  end

  assign o_freq_select = r_freq_select;
  assign o_note_on     = r_note_on;
  assign o_note_off    = !r_note_on;
  assign o_note_strobe = r_note_strobe;
  assign o_rx_error    = w_rx_error;
  assign o_active_note = r_active_note;

endmodule
